// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
//   state_t          : launch FSM state encoding (2 bits)
//   UART_BYTE_W      : width of one serial data byte
//   UART_FIFO_DEPTH  : default depth of the transmit byte FIFO
package uart_pkg;

  localparam int UART_BYTE_W     = 8;
  localparam int UART_FIFO_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/uart_tx_feeder_sync_fifo.sv
// sync_fifo: single-clock FIFO with registered pointers and level.
// push/pop must already be qualified by the caller (no push when full,
// no pop when empty). rd_data always shows the entry at the read pointer.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   push, wr_data     : store wr_data this cycle
//   pop               : retire the head entry this cycle
//   rd_data           : head entry (valid when !empty)
//   full, empty, level: occupancy, derived from the registered level
module sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = UART_FIFO_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int W      = UART_BYTE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [W-1:0]      wr_data,
  input  logic              pop,
  output logic [W-1:0]      rd_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level
);

  localparam int LW = ADDR_W + 1;

  logic [W-1:0]      mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(push) - LW'(pop);
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);

endmodule

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO plus launch controller in front of a UART
// transmitter. Bytes are accepted at clock rate and launched one at a time,
// paced by tx_busy.
// Optional build macro UART_TX_FEEDER_DROPCNT_EN adds drop_cnt, a saturating
// count of dropped writes.
// Handshake: a write is accepted on any cycle with wr_en && !full; a launch
// is a single-cycle tx_start with tx_data valid, issued only while the
// transmitter reports !tx_busy; tx_data holds until the FSM returns to IDLE.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   wr_en, wr_data     : system-side byte push
//   full, empty, level : FIFO occupancy
//   overflow           : sticky, a write was dropped
//   tx_start, tx_data  : launch pulse and byte to the transmitter
//   tx_busy            : transmitter busy flag
//   state              : launch FSM state (debug observation)
//   drop_cnt           : dropped-write count (only with the macro defined)
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH  = UART_FIFO_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [UART_BYTE_W-1:0] wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [ADDR_W:0]        level,
  output logic                   overflow,
  output logic                   tx_start,
  output logic [UART_BYTE_W-1:0] tx_data,
  input  logic                   tx_busy,
`ifdef UART_TX_FEEDER_DROPCNT_EN
  output logic [7:0]             drop_cnt,
`endif
  output state_t                 state
);

  logic                   push;
  logic                   pop;
  logic                   drop;
  logic [UART_BYTE_W-1:0] head;

  // full comes from the registered level, so a same-cycle pop does not
  // make room for a write that arrives while full.
  assign push = wr_en && !full;
  assign drop = wr_en && full;
  assign pop  = (state == IDLE) && !empty && !tx_busy;

  sync_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .W      (UART_BYTE_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (wr_data),
    .pop     (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      tx_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            tx_data  <= head;
            tx_start <= 1'b1;
            state    <= LAUNCH;
          end
        end
        LAUNCH: begin
          tx_start <= 1'b0;
          state    <= WAIT_BUSY;
        end
        // The transmitter raises busy one cycle after sampling tx_start.
        WAIT_BUSY: begin
          if (tx_busy) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (!tx_busy) state <= IDLE;
        end
        default: begin
          tx_start <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)       overflow <= 1'b0;
    else if (drop) overflow <= 1'b1;
  end

`ifdef UART_TX_FEEDER_DROPCNT_EN
  always_ff @(posedge clk) begin
    if (rst)                           drop_cnt <= '0;
    else if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: directed vectors, behavioural transmitter, and a
// scoreboard whose monitor checks every tx_start against the expected queue.
module tb_uart_tx_feeder;
  import uart_pkg::*;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_en = 1'b0;
  logic [7:0]        wr_data = 8'h00;
  logic              full, empty, overflow, tx_start, tx_busy;
  logic [ADDR_W:0]   level;
  logic [7:0]        tx_data;
  state_t            st;
`ifdef UART_TX_FEEDER_DROPCNT_EN
  logic [7:0]        drop_cnt;
`endif

  int tests = 0;
  int fails = 0;
  int launches = 0;
  logic [7:0] exp_q[$];

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  uart_tx_feeder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
`ifdef UART_TX_FEEDER_DROPCNT_EN
    .drop_cnt (drop_cnt),
`endif
    .state    (st)
  );

  // ---------------- transmitter model ----------------
  // Busy for 10 cycles starting the cycle after tx_start is sampled; it is
  // not reset by rst, so an active frame runs to completion.
  int  busy_cnt = 0;
  logic hold_busy = 1'b0;
  always @(posedge clk) begin
    if (tx_start)          busy_cnt <= 10;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = hold_busy || (busy_cnt != 0);

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every launch must match the queue head, never repeat on
  // consecutive cycles, and never occur while the transmitter is busy.
  logic prev_start = 1'b0;
  always @(negedge clk) begin
    if (tx_start) begin
      launches++;
      if (exp_q.size() == 0) begin
        check("unexpected_launch", {24'h0, tx_data}, 32'hFFFF_FFFF);
      end else begin
        check("launch_data", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
      end
      check("launch_not_busy", {31'h0, tx_busy}, 32'h0);
      check("launch_single_cycle", {31'h0, prev_start}, 32'h0);
    end
    prev_start = tx_start;
  end

  // ---------------- drivers ----------------
  task automatic write_byte(input logic [7:0] d, input bit expect_sent);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = d;
    if (expect_sent) exp_q.push_back(d);
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && st == IDLE && !tx_busy) begin
        done = 1'b1;
        break;
      end
    end
    check(name, {31'h0, done}, 32'h1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;

    // 1. reset
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_empty",    {31'h0, empty},    32'h1);
    check("rst_full",     {31'h0, full},     32'h0);
    check("rst_level",    {27'h0, level},    32'h0);
    check("rst_overflow", {31'h0, overflow}, 32'h0);
    check("rst_tx_start", {31'h0, tx_start}, 32'h0);
    check("rst_tx_data",  {24'h0, tx_data},  32'h0);
    check("rst_state",    {30'h0, st},       32'h0);
`ifdef UART_TX_FEEDER_DROPCNT_EN
    check("rst_drop_cnt", {24'h0, drop_cnt}, 32'h0);
`endif
    rst = 1'b0;

    // 2. single byte latency
    write_byte(8'hA5, 1'b1);
    @(negedge clk);
    wr_en = 1'b0;
    check("lat_no_start_yet", {31'h0, tx_start}, 32'h0);
    check("lat_level_1",      {27'h0, level},    32'h1);
    @(negedge clk);
    check("lat_start",   {31'h0, tx_start}, 32'h1);
    check("lat_data",    {24'h0, tx_data},  32'hA5);
    @(negedge clk);
    check("lat_start_low", {31'h0, tx_start}, 32'h0);
    check("lat_level_0",   {27'h0, level},    32'h0);
    check("lat_empty",     {31'h0, empty},    32'h1);
    check("lat_hold_data", {24'h0, tx_data},  32'hA5);
    wait_idle("drain_single");

    // 3. burst of three
    base = launches;
    write_byte(8'h01, 1'b1);
    write_byte(8'h02, 1'b1);
    write_byte(8'h03, 1'b1);
    @(negedge clk);
    wr_en = 1'b0;
    wait_idle("drain_burst");
    check("burst_launches", launches - base, 32'd3);

    // 4. fill while busy held, then overflow
    hold_busy = 1'b1;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (i == 15) begin
        check("fill_level_15", {27'h0, level}, 32'd15);
        check("fill_not_full", {31'h0, full},  32'h0);
      end
      if (i == 16) begin
        check("fill_full",     {31'h0, full},     32'h1);
        check("fill_level_16", {27'h0, level},    32'd16);
        check("fill_no_ovf",   {31'h0, overflow}, 32'h0);
      end
      wr_en   = 1'b1;
      wr_data = 8'h10 + 8'(i);
      if (i < 16) exp_q.push_back(wr_data);
    end
    @(negedge clk);
    wr_en = 1'b0;
    check("ovf_set",        {31'h0, overflow}, 32'h1);
    check("ovf_level_16",   {27'h0, level},    32'd16);
    check("ovf_no_launch",  {31'h0, tx_start}, 32'h0);
`ifdef UART_TX_FEEDER_DROPCNT_EN
    check("ovf_drop_cnt",   {24'h0, drop_cnt}, 32'h1);
`endif
    hold_busy = 1'b0;
    wait_idle("drain_full");
    check("ovf_sticky",     {31'h0, overflow}, 32'h1);
    check("drain_empty",    {31'h0, empty},    32'h1);

    // 5. push coincident with the IDLE->LAUNCH pop at level 3
    @(negedge clk);
    hold_busy = 1'b1;
    wr_en = 1'b1; wr_data = 8'h31; exp_q.push_back(8'h31);
    write_byte(8'h32, 1'b1);
    write_byte(8'h33, 1'b1);
    @(negedge clk);
    check("pre_pop_level_3", {27'h0, level}, 32'd3);
    hold_busy = 1'b0;
    wr_en = 1'b1; wr_data = 8'h34; exp_q.push_back(8'h34);
    @(negedge clk);
    wr_en = 1'b0;
    check("pushpop_start", {31'h0, tx_start}, 32'h1);
    check("pushpop_level", {27'h0, level},    32'd3);
    wait_idle("drain_pushpop");

    // 6. reset during WAIT_DONE with five queued
    write_byte(8'h40, 1'b1);
    for (int i = 1; i < 6; i++) write_byte(8'h40 + 8'(i), 1'b0);
    @(negedge clk);
    wr_en = 1'b0;
    check("pre_rst_state", {30'h0, st},    32'(WAIT_DONE));
    check("pre_rst_level", {27'h0, level}, 32'd5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_level",    {27'h0, level},    32'h0);
    check("mid_rst_empty",    {31'h0, empty},    32'h1);
    check("mid_rst_state",    {30'h0, st},       32'(IDLE));
    check("mid_rst_start",    {31'h0, tx_start}, 32'h0);
    check("mid_rst_overflow", {31'h0, overflow}, 32'h0);
    base = launches;
    repeat (30) @(negedge clk);
    check("post_rst_no_launch", launches - base, 32'd0);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time bound in case a wait ever hangs.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
Byte FIFO plus launch controller that sits directly upstream of the uart transmitter. It accepts bytes from the system side at full clock rate and drives the transmitter's tx_start/tx_data pair. It paces launches on the transmitter's tx_busy, so back-to-back bytes are serialized without loss or duplication. This decouples bursty producers, such as a command responder, from the 10-clock-per-byte serial rate.

Parameters:
DEPTH, 16, FIFO entries; must be a power of 2, minimum 2.
ADDR_W, 4, log2(DEPTH); pointer width.

Ports:
clk  in  1  single system clock, rising edge.
rst  in  1  synchronous, active-high reset.
wr_en  in  1  push wr_data this cycle.
wr_data  in  8  byte to queue.
full  out  1  high when level == DEPTH.
empty  out  1  high when level == 0.
level  out  ADDR_W+1  current number of entries, 0..DEPTH.
overflow  out  1  sticky; a write was dropped.
tx_start  out  1  one-cycle launch pulse to the transmitter.
tx_data  out  8  byte for the transmitter; stable from the launch until return to IDLE.
tx_busy  in  1  transmitter busy flag.

Behaviour:
- Reset (rst sampled high on a clk edge): rd_ptr=0, wr_ptr=0, level=0, empty=1, full=0, overflow=0, tx_start=0, tx_data=8'h00, state=IDLE. FIFO memory contents are not reset.
- Reset mid-transfer aborts the FSM and flushes the queue. A transmitter already active finishes its frame on its own.
- Write: if wr_en && !full, store wr_data at wr_ptr, then wr_ptr++ (wraps mod DEPTH).
- Write when full: the byte is dropped, pointers do not change, and overflow is set to 1 until reset.
- full is evaluated on the registered level. A write arriving while full is dropped even if a pop happens in the same cycle.
- FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
  - IDLE: if !empty && !tx_busy, then tx_data <= mem[rd_ptr], rd_ptr++, tx_start <= 1, and go to LAUNCH. Otherwise stay in IDLE.
  - LAUNCH: lasts exactly 1 cycle with tx_start=1. Then tx_start <= 0 and go to WAIT_BUSY.
  - WAIT_BUSY: when tx_busy=1, go to WAIT_DONE. The paired transmitter raises busy the cycle after it samples tx_start.
  - WAIT_DONE: when tx_busy=0, go to IDLE. The earliest next launch is the following cycle.
- A pop happens only on the IDLE->LAUNCH transition.
- Simultaneous push and pop: both take effect and level is unchanged.
- Level arithmetic: level_next = level + push - pop, where push and pop are 1-bit qualified strobes. The value never leaves the range 0..DEPTH.
- Latency: a byte written into an empty FIFO while idle appears on tx_data with tx_start=1 two cycles after the wr_en cycle (one cycle to store, one cycle to launch).
- tx_start is never high for two consecutive cycles.
- Byte order is strictly FIFO.

Optional Feature:
Macro: UART_TX_FEEDER_DROPCNT_EN.
- Defined: adds output drop_cnt [7:0]. It increments on each dropped write, saturates at 8'hFF, and is cleared by rst.
- Undefined: the port and counter are absent. Only the sticky overflow bit reports drops.

Decomposition:
- Shared package uart_pkg holds:
  - the FSM state typedef (IDLE/LAUNCH/WAIT_BUSY/WAIT_DONE, 2-bit encoding);
  - localparam UART_BYTE_W = 8;
  - the default FIFO depth constant.
- One natural sub-module, sync_fifo. It is a parameterized storage/pointer/level block with push, pop, full, empty and level ports.
- The launch FSM and overflow logic stay in uart_tx_feeder.

Test Plan:
Use a behavioural transmitter model: tx_busy rises 1 cycle after tx_start is sampled and stays high 10 cycles.
1. Apply rst 2 cycles -> empty=1, full=0, level=0, overflow=0, tx_start=0, tx_data=8'h00.
2. Write 8'hA5 once while idle -> tx_start=1 for exactly one cycle, 2 cycles after wr_en, with tx_data=8'hA5; then level=0 and empty=1.
3. Burst-write 8'h01, 8'h02, 8'h03 on consecutive cycles -> exactly three tx_start pulses with data 01, 02, 03 in order. Each pulse waits for tx_busy to fall, and none falls inside a busy window.
4. Hold tx_busy=1, write 17 bytes 8'h10..8'h20 -> full=1 and level=16 after the 16th write; 8'h20 is dropped and overflow=1. With DROPCNT_EN, drop_cnt=1. Release busy -> bytes 8'h10..8'h1F are sent in order.
5. With level=3, write during the IDLE->LAUNCH pop cycle -> level stays 3 and the new byte is sent last.
6. Assert rst during WAIT_DONE with level=5 -> next cycle level=0, empty=1, state=IDLE, and no further tx_start appears.
